debug_trace: RTL and testbench
==============================

Name: debug_trace

Overview:
- Parametrised on-chip trace capture for the CPU's debug probe buses (PC, STATE, OPCODE, ROM, SP, ADDR and future additions).
- Records NCH probe channels per valid CPU cycle into a circular buffer. Supports a masked-compare trigger on a selectable channel and a programmable post-trigger count, then freezes.
- A frozen capture is read back oldest-first by index, for the simulation bench and for the HEX display path (RD_DATA drives HEX digits via the CPU top).

Parameters:
- NCH, 6, number of probe channels
- W, 16, width of each probe channel
- DEPTH, 64, buffer entries per channel; power of two, at least 4
- AW, $clog2(DEPTH), index width (derived, not overridden)
- CW, $clog2(NCH), channel-select width (derived)

Ports:
- CLK1_50  in  1  system clock; all state changes on its rising edge
- RST  in  1  synchronous, active-high reset
- PROBE  in  NCH*W  probe channels packed; channel c occupies [c*W +: W]
- PROBE_VALID  in  1  sample strobe (one CPU cycle)
- ARM  in  1  single-cycle pulse; clears the capture and starts recording
- TRIG_CH  in  CW  channel compared for the trigger
- TRIG_VAL  in  W  trigger compare value
- TRIG_MASK  in  W  bit mask; 1 = compare this bit
- POST_CNT  in  AW  number of samples stored after the trigger sample
- RD_CH  in  CW  readback channel
- RD_IDX  in  AW  readback index, 0 = oldest stored sample
- RD_DATA  out  W  registered readback data
- ST  out  2  state: 0 IDLE, 1 ARMED, 2 POST, 3 DONE
- FILL  out  AW+1  samples stored, saturating at DEPTH
- TRIG_POS  out  AW  oldest-first index of the trigger sample (valid in DONE)

Behaviour:
- Reset: ST=IDLE, FILL=0, TRIG_POS=0, RD_DATA=0, write pointer=0, post counter=0. Buffer RAM is not cleared.
- Trigger hit = ((PROBE[TRIG_CH] ^ TRIG_VAL) & TRIG_MASK) == 0. TRIG_MASK=0 hits on the first valid sample.
- IDLE: no writes. On ARM, go to ARMED next cycle with FILL=0 and pointer=0. The sample in the ARM cycle is not recorded.
- ARMED: each PROBE_VALID writes all NCH channels at the pointer, increments the pointer (wraps mod DEPTH) and increments FILL (saturates at DEPTH).
  - If that sample hits: latch the trigger pointer, load the post counter with POST_CNT, and go to POST. If POST_CNT=0, go to DONE instead.
- POST: each PROBE_VALID stores a sample and decrements the post counter. The store that brings the counter to 0 moves to DONE. Triggers are ignored.
- DONE: no writes; contents are frozen. ARM restarts capture exactly as from IDLE.
- ARM in ARMED or POST: restart. ARM takes priority over a same-cycle sample or trigger, and that sample is discarded.
- PROBE_VALID low: nothing advances in any state.
- Readback is valid in any state:
  - Physical address = (FILL==DEPTH) ? (ptr + RD_IDX) mod DEPTH : RD_IDX.
  - RD_DATA is registered with 1-cycle latency.
  - RD_DATA = 0 when RD_IDX >= FILL.
- TRIG_POS = oldest-first index of the trigger sample, computed with the same rule as the readback address; latched on entry to DONE.
- Pre-trigger history is limited by DEPTH. If POST_CNT is at least DEPTH-FILL-at-trigger, the oldest entries, up to and including the trigger sample, may be overwritten. This is permitted; TRIG_POS is then meaningless. Benches do not check TRIG_POS in that case.
- RST mid-capture returns to IDLE on the next edge and wins over ARM and PROBE_VALID.

Decomposition:
- Package debug_trace_pkg holds the ST encoding as a typedef enum (ST_IDLE, ST_ARMED, ST_POST, ST_DONE) and a probe-channel index localparam set (CH_PC=0, CH_STATE=1, CH_OPCODE=2, CH_ROM=3, CH_SP=4, CH_ADDR=5).
- One sub-module, trace_ram: simple dual-port RAM, 1 write port and 1 read port, NCH*W wide, DEPTH deep, registered read. It is inferable as M10K.

Test Plan (DEPTH=8, NCH=6, W=16):
- RST held 3 cycles, then released -> ST=0, FILL=0, RD_DATA=0; PROBE_VALID pulses ignored in IDLE (FILL stays 0).
- ARM, then 3 valid samples with PC=0x0010,0x0011,0x0012, TRIG_MASK=0xFFFF, TRIG_VAL=0x0011, POST_CNT=1 -> DONE after the 3rd sample; FILL=3; TRIG_POS=1; RD_CH=0 with RD_IDX=0..2 returns 0x0010,0x0011,0x0012 one cycle after each index.
- ARM, 12 valid samples PC=0x0100..0x010B, trigger PC=0x010A, POST_CNT=1 -> FILL=8; oldest-first readback 0x0104..0x010B; TRIG_POS=6.
- TRIG_MASK=0x0000, POST_CNT=2 -> trigger on the first sample; DONE after 3 samples; TRIG_POS=0.
- ARM asserted in POST together with PROBE_VALID -> ST=ARMED, FILL=0, that sample not stored. RD_IDX=0 returns 0 until the next valid sample.
- RST asserted while in POST with FILL=5 -> next cycle ST=0, FILL=0; the following ARM behaves normally.

Source files
------------

// File: rtl/debug_trace_pkg.sv
// Shared types and channel map for the debug trace capture block.
package debug_trace_pkg;

    // Capture state as seen on the ST output.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } st_e;

    // Probe channel slots within the packed PROBE bus.
    localparam int unsigned CH_PC     = 0;
    localparam int unsigned CH_STATE  = 1;
    localparam int unsigned CH_OPCODE = 2;
    localparam int unsigned CH_ROM    = 3;
    localparam int unsigned CH_SP     = 4;
    localparam int unsigned CH_ADDR   = 5;

endpackage

// File: rtl/debug_trace_ram.sv
// Simple dual-port trace storage: one write port, one registered read port.
module trace_ram #(
    parameter int unsigned DW    = 96,
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    // Write port; contents are never cleared.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read port (maps onto block RAM output register).
    always_ff @(posedge i_clk) begin
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/debug_trace.sv
// Trace capture of NCH probe channels into a circular buffer with masked
// trigger, post-trigger count and oldest-first readback of a frozen capture.
module debug_trace
    import debug_trace_pkg::*;
#(
    parameter int unsigned NCH   = 6,
    parameter int unsigned W     = 16,
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = $clog2(DEPTH),
    parameter int unsigned CW    = $clog2(NCH)
) (
    input  logic             CLK1_50,
    input  logic             RST,
    input  logic [NCH*W-1:0] PROBE,
    input  logic             PROBE_VALID,
    input  logic             ARM,
    input  logic [CW-1:0]    TRIG_CH,
    input  logic [W-1:0]     TRIG_VAL,
    input  logic [W-1:0]     TRIG_MASK,
    input  logic [AW-1:0]    POST_CNT,
    input  logic [CW-1:0]    RD_CH,
    input  logic [AW-1:0]    RD_IDX,
    output logic [W-1:0]     RD_DATA,
    output logic [1:0]       ST,
    output logic [AW:0]      FILL,
    output logic [AW-1:0]    TRIG_POS
);

    localparam int unsigned DW   = NCH * W;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    st_e           r_st;
    st_e           w_st_nx;
    logic [AW-1:0] r_ptr;
    logic [AW-1:0] r_post;
    logic [AW-1:0] r_trig_ptr;
    logic [AW-1:0] r_trig_pos;
    logic [AW:0]   r_fill;
    logic [CW-1:0] r_rd_ch;
    logic          r_rd_zero;

    logic          w_we;
    logic          w_clear;
    logic          w_latch_trig;
    logic          w_load_post;
    logic          w_dec_post;
    logic          w_done_entry;
    logic          w_hit;
    logic [W-1:0]  w_trig_word;
    logic [W-1:0]  w_rd_word;
    logic [AW-1:0] w_ptr_inc;
    logic [AW-1:0] w_trig_phys;
    logic [AW-1:0] w_trig_pos;
    logic [AW-1:0] w_rd_addr;
    logic [AW:0]   w_fill_inc;
    logic [DW-1:0] w_ram_q;

    // Select the trigger channel; out-of-range selects compare against zero.
    always_comb begin
        w_trig_word = '0;
        for (int c = 0; c < int'(NCH); c++) begin
            if (TRIG_CH == CW'(c)) begin
                w_trig_word = PROBE[c*W +: W];
            end
        end
    end

    assign w_hit      = ((w_trig_word ^ TRIG_VAL) & TRIG_MASK) == '0;
    assign w_ptr_inc  = r_ptr + AW'(1);
    assign w_fill_inc = (r_fill == FULL) ? FULL : r_fill + (AW+1)'(1);

    // Oldest-first index of the trigger, judged against post-store ptr/fill.
    assign w_trig_pos = (w_fill_inc == FULL) ? (w_trig_phys - w_ptr_inc) : w_trig_phys;

    // Once wrapped, the oldest sample sits at the write pointer.
    assign w_rd_addr  = (r_fill == FULL) ? (r_ptr + RD_IDX) : RD_IDX;

    // Capture state register.
    always_ff @(posedge CLK1_50) begin
        if (RST) begin
            r_st <= ST_IDLE;
        end else begin
            r_st <= w_st_nx;
        end
    end

    // Next state and datapath strobes; ARM outranks a same-cycle sample.
    always_comb begin
        w_st_nx      = r_st;
        w_we         = 1'b0;
        w_clear      = 1'b0;
        w_latch_trig = 1'b0;
        w_load_post  = 1'b0;
        w_dec_post   = 1'b0;
        w_done_entry = 1'b0;
        w_trig_phys  = r_trig_ptr;
        case (r_st)
            ST_IDLE, ST_DONE: begin
                if (ARM) begin
                    w_clear = 1'b1;
                    w_st_nx = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (ARM) begin
                    w_clear = 1'b1;
                end else if (PROBE_VALID) begin
                    w_we = 1'b1;
                    if (w_hit) begin
                        w_latch_trig = 1'b1;
                        if (POST_CNT == '0) begin
                            w_st_nx      = ST_DONE;
                            w_done_entry = 1'b1;
                            w_trig_phys  = r_ptr;
                        end else begin
                            w_st_nx     = ST_POST;
                            w_load_post = 1'b1;
                        end
                    end
                end
            end
            ST_POST: begin
                if (ARM) begin
                    w_clear = 1'b1;
                    w_st_nx = ST_ARMED;
                end else if (PROBE_VALID) begin
                    w_we       = 1'b1;
                    w_dec_post = 1'b1;
                    if (r_post == AW'(1)) begin
                        w_st_nx      = ST_DONE;
                        w_done_entry = 1'b1;
                    end
                end
            end
            default: w_st_nx = ST_IDLE;
        endcase
    end

    // Pointer, fill, post counter, trigger bookkeeping and readback pipeline.
    always_ff @(posedge CLK1_50) begin
        if (RST) begin
            r_ptr      <= '0;
            r_fill     <= '0;
            r_post     <= '0;
            r_trig_ptr <= '0;
            r_trig_pos <= '0;
            r_rd_ch    <= '0;
            r_rd_zero  <= 1'b1;
        end else begin
            if (w_clear) begin
                r_ptr  <= '0;
                r_fill <= '0;
                r_post <= '0;
            end else if (w_we) begin
                r_ptr  <= w_ptr_inc;
                r_fill <= w_fill_inc;
            end
            if (w_latch_trig) begin
                r_trig_ptr <= r_ptr;
            end
            if (w_load_post) begin
                r_post <= POST_CNT;
            end else if (w_dec_post) begin
                r_post <= r_post - AW'(1);
            end
            if (w_done_entry) begin
                r_trig_pos <= w_trig_pos;
            end
            r_rd_ch   <= RD_CH;
            r_rd_zero <= ({1'b0, RD_IDX} >= r_fill);
        end
    end

    trace_ram #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .i_clk   (CLK1_50),
        .i_we    (w_we),
        .i_waddr (r_ptr),
        .i_wdata (PROBE),
        .i_raddr (w_rd_addr),
        .o_rdata (w_ram_q)
    );

    // Channel select on the registered RAM word, with registered select/gate.
    always_comb begin
        w_rd_word = '0;
        for (int c = 0; c < int'(NCH); c++) begin
            if (r_rd_ch == CW'(c)) begin
                w_rd_word = w_ram_q[c*W +: W];
            end
        end
    end

    assign RD_DATA  = r_rd_zero ? '0 : w_rd_word;
    assign ST       = r_st;
    assign FILL     = r_fill;
    assign TRIG_POS = r_trig_pos;

endmodule

// File: tb/tb_debug_trace.sv
// Bench for debug_trace at DEPTH=8: readback tables through a scoreboard queue
// plus hand-written capture sequences.
module tb_debug_trace;
    import debug_trace_pkg::*;

    localparam int unsigned NCH   = 6;
    localparam int unsigned W     = 16;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 3;
    localparam int unsigned CW    = 3;

    logic             CLK1_50 = 1'b0;
    logic             RST = 1'b1;
    logic [NCH*W-1:0] PROBE = '0;
    logic             PROBE_VALID = 1'b0;
    logic             ARM = 1'b0;
    logic [CW-1:0]    TRIG_CH = '0;
    logic [W-1:0]     TRIG_VAL = '0;
    logic [W-1:0]     TRIG_MASK = '0;
    logic [AW-1:0]    POST_CNT = '0;
    logic [CW-1:0]    RD_CH = '0;
    logic [AW-1:0]    RD_IDX = '0;
    logic [W-1:0]     RD_DATA;
    logic [1:0]       ST;
    logic [AW:0]      FILL;
    logic [AW-1:0]    TRIG_POS;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int            phase;
        logic [CW-1:0] ch;
        logic [AW-1:0] idx;
        logic [W-1:0]  exp;
    } rd_vec_t;

    rd_vec_t      tbl[$];
    logic [W-1:0] exp_q[$];

    debug_trace #(
        .NCH   (NCH),
        .W     (W),
        .DEPTH (DEPTH)
    ) dut (
        .CLK1_50     (CLK1_50),
        .RST         (RST),
        .PROBE       (PROBE),
        .PROBE_VALID (PROBE_VALID),
        .ARM         (ARM),
        .TRIG_CH     (TRIG_CH),
        .TRIG_VAL    (TRIG_VAL),
        .TRIG_MASK   (TRIG_MASK),
        .POST_CNT    (POST_CNT),
        .RD_CH       (RD_CH),
        .RD_IDX      (RD_IDX),
        .RD_DATA     (RD_DATA),
        .ST          (ST),
        .FILL        (FILL),
        .TRIG_POS    (TRIG_POS)
    );

    always #5 CLK1_50 = ~CLK1_50;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge CLK1_50);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input int phase, input int ch, input int idx, input int exp);
        rd_vec_t v;
        v.phase = phase;
        v.ch    = CW'(ch);
        v.idx   = AW'(idx);
        v.exp   = W'(exp);
        tbl.push_back(v);
    endtask

    // Channel c carries pc + c*0x1000.
    task automatic set_probe(input logic [W-1:0] pc);
        for (int c = 0; c < int'(NCH); c++) begin
            PROBE[c*W +: W] = pc + W'(c * 'h1000);
        end
    endtask

    task automatic sample(input logic [W-1:0] pc);
        set_probe(pc);
        PROBE_VALID = 1'b1;
        step();
        PROBE_VALID = 1'b0;
    endtask

    task automatic arm_pulse();
        ARM = 1'b1;
        step();
        ARM = 1'b0;
    endtask

    task automatic rd_check(input rd_vec_t v);
        logic [W-1:0] e;
        RD_CH  = v.ch;
        RD_IDX = v.idx;
        exp_q.push_back(v.exp);
        step();
        if (exp_q.size() == 0) begin
            chk("rd_queue_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk($sformatf("rd_ph%0d_ch%0d_idx%0d", v.phase, v.ch, v.idx), 32'(RD_DATA), 32'(e));
        end
    endtask

    task automatic run_table(input int phase);
        foreach (tbl[i]) begin
            if (tbl[i].phase == phase) begin
                rd_check(tbl[i]);
            end
        end
    endtask

    initial begin
        add_vec(1, 0, 0, 'h0010);
        add_vec(1, 0, 1, 'h0011);
        add_vec(1, 0, 2, 'h0012);
        add_vec(1, 0, 3, 'h0000);
        add_vec(1, 5, 1, 'h5011);
        add_vec(1, 2, 2, 'h2012);
        for (int i = 0; i < 8; i++) add_vec(2, 0, i, 'h0104 + i);
        add_vec(2, 3, 6, 'h310A);
        add_vec(3, 0, 0, 'h0700);
        add_vec(3, 0, 2, 'h0702);
        add_vec(3, 0, 7, 'h0000);
        add_vec(5, 0, 1, 'h0501);
        add_vec(5, 4, 0, 'h4500);
        add_vec(5, 0, 2, 'h0000);

        // Reset and IDLE behaviour.
        RST = 1'b1;
        repeat (3) step();
        RST = 1'b0;
        step();
        chk("reset_st", 32'(ST), 32'(ST_IDLE));
        chk("reset_fill", 32'(FILL), 0);
        chk("reset_rd_data", 32'(RD_DATA), 0);
        chk("reset_trig_pos", 32'(TRIG_POS), 0);
        sample(16'h0001);
        sample(16'h0002);
        chk("idle_fill", 32'(FILL), 0);
        chk("idle_st", 32'(ST), 32'(ST_IDLE));

        // Basic capture: trigger on 0x0011, one post sample.
        TRIG_CH = CW'(CH_PC); TRIG_MASK = 16'hFFFF; TRIG_VAL = 16'h0011; POST_CNT = 3'd1;
        arm_pulse();
        chk("p1_armed", 32'(ST), 32'(ST_ARMED));
        sample(16'h0010);
        chk("p1_st_s1", 32'(ST), 32'(ST_ARMED));
        sample(16'h0011);
        chk("p1_st_s2", 32'(ST), 32'(ST_POST));
        sample(16'h0012);
        chk("p1_st_done", 32'(ST), 32'(ST_DONE));
        chk("p1_fill", 32'(FILL), 3);
        chk("p1_trig_pos", 32'(TRIG_POS), 1);
        run_table(1);

        // Wraparound: 12 samples into 8 entries.
        TRIG_VAL = 16'h010A; POST_CNT = 3'd1;
        arm_pulse();
        for (int i = 0; i < 11; i++) sample(W'(16'h0100 + i));
        chk("p2_st_post", 32'(ST), 32'(ST_POST));
        sample(16'h010B);
        chk("p2_st_done", 32'(ST), 32'(ST_DONE));
        chk("p2_fill", 32'(FILL), 8);
        chk("p2_trig_pos", 32'(TRIG_POS), 6);
        run_table(2);

        // Zero mask triggers on the first sample; DONE freezes the capture.
        TRIG_MASK = 16'h0000; POST_CNT = 3'd2;
        arm_pulse();
        sample(16'h0700);
        chk("p3_st_s1", 32'(ST), 32'(ST_POST));
        sample(16'h0701);
        chk("p3_st_s2", 32'(ST), 32'(ST_POST));
        sample(16'h0702);
        chk("p3_st_done", 32'(ST), 32'(ST_DONE));
        chk("p3_trig_pos", 32'(TRIG_POS), 0);
        sample(16'h0703);
        chk("p3_fill_frozen", 32'(FILL), 3);
        run_table(3);

        // ARM with a same-cycle sample while in POST.
        TRIG_MASK = 16'hFFFF; TRIG_VAL = 16'h0200; POST_CNT = 3'd3;
        arm_pulse();
        sample(16'h01FF);
        sample(16'h0200);
        sample(16'h0201);
        chk("p4_st_post", 32'(ST), 32'(ST_POST));
        chk("p4_fill3", 32'(FILL), 3);
        set_probe(16'h0202);
        ARM = 1'b1; PROBE_VALID = 1'b1;
        step();
        ARM = 1'b0; PROBE_VALID = 1'b0;
        chk("p4_rearm_st", 32'(ST), 32'(ST_ARMED));
        chk("p4_rearm_fill", 32'(FILL), 0);
        begin
            rd_vec_t v;
            v.phase = 4; v.ch = '0; v.idx = '0; v.exp = '0;
            rd_check(v);
            sample(16'h0300);
            chk("p4_fill1", 32'(FILL), 1);
            v.exp = 16'h0300;
            rd_check(v);
        end

        // RST in POST with FILL=5 wins over ARM and PROBE_VALID.
        TRIG_VAL = 16'h0404; POST_CNT = 3'd3;
        arm_pulse();
        for (int i = 0; i < 5; i++) sample(W'(16'h0400 + i));
        chk("p5_st_post", 32'(ST), 32'(ST_POST));
        chk("p5_fill5", 32'(FILL), 5);
        RST = 1'b1; ARM = 1'b1; PROBE_VALID = 1'b1;
        step();
        RST = 1'b0; ARM = 1'b0; PROBE_VALID = 1'b0;
        chk("p5_rst_st", 32'(ST), 32'(ST_IDLE));
        chk("p5_rst_fill", 32'(FILL), 0);
        // Trigger on the SP channel with POST_CNT=0: straight to DONE.
        TRIG_CH = CW'(CH_SP); TRIG_VAL = 16'h4501; POST_CNT = 3'd0;
        arm_pulse();
        chk("p5_armed", 32'(ST), 32'(ST_ARMED));
        sample(16'h0500);
        chk("p5_st_s1", 32'(ST), 32'(ST_ARMED));
        sample(16'h0501);
        chk("p5_st_done", 32'(ST), 32'(ST_DONE));
        chk("p5_fill2", 32'(FILL), 2);
        chk("p5_trig_pos", 32'(TRIG_POS), 1);
        run_table(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
